// File: rtl/gate_pkg.sv
// +----------------------------------------------------------------------------+
// | gate_pkg: shared state encoding and unity-gain helper for gate_envelope.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package gate_pkg;

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    ATTACK  = 3'd1,
    OPEN    = 3'd2,
    HOLD    = 3'd3,
    RELEASE = 3'd4
  } gate_state_t;

  function automatic int gmax(input int gain_w);
    return 1 << gain_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gain_mult.sv
// +----------------------------------------------------------------------------+
// | gain_mult: registered signed sample x unsigned gain, scaled by >>> GAIN_W. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module gain_mult #(
  parameter int WIDTH  = 16,
  parameter int GAIN_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] sample,
  input  logic [GAIN_W:0]         gain,
  output logic signed [WIDTH-1:0] out,
  output logic                    out_valid
);

  localparam int PW = WIDTH + GAIN_W + 1;

  logic signed [PW-1:0]    sample_ext;
  logic signed [PW-1:0]    gain_ext;
  logic signed [PW-1:0]    prod;
  logic signed [WIDTH-1:0] out_d, out_q;
  logic                    out_valid_d, out_valid_q;
  logic                    unused_prod_bits;

  assign sample_ext = {{(GAIN_W + 1){sample[WIDTH-1]}}, sample};
  assign gain_ext   = {{WIDTH{1'b0}}, gain};
  assign prod       = sample_ext * gain_ext;

  // Taking bits above GAIN_W is the arithmetic shift; gain <= GMAX keeps it in range.
  assign unused_prod_bits = ^{prod[PW-1:GAIN_W+WIDTH], prod[GAIN_W-1:0]};

  always_comb begin
    out_d       = out_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      out_d = prod[GAIN_W +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: rtl/gate_envelope.sv
// +----------------------------------------------------------------------------+
// | gate_envelope: attack/hold/release gain envelope applied to mic samples.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module gate_envelope
  import gate_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int GAIN_W       = 8,
  parameter int ATTACK_STEP  = 16,
  parameter int RELEASE_STEP = 2,
  parameter int HOLD_SAMPLES = 4800
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        gate_in,
  input  logic                    gate_valid,
  input  logic signed [WIDTH-1:0] audio_in,
  input  logic                    audio_valid,
  output logic signed [WIDTH-1:0] audio_out,
  output logic                    audio_out_valid,
  output logic                    gate_open,
  output logic [GAIN_W:0]         gain_out
);

  localparam int GW   = GAIN_W + 1;
  localparam int SW   = GAIN_W + 2;
  localparam int HC_W = (HOLD_SAMPLES == 0) ? 1 : $clog2(HOLD_SAMPLES + 1);

  localparam logic [GW-1:0]   GMAX      = GW'(gmax(GAIN_W));
  localparam logic [SW-1:0]   ATK       = SW'(ATTACK_STEP);
  localparam logic [GW-1:0]   REL       = GW'(RELEASE_STEP);
  localparam logic [HC_W-1:0] HOLD_INIT = (HOLD_SAMPLES == 0) ? '0 : HC_W'(HOLD_SAMPLES - 1);

  gate_state_t     state_d, state_q;
  logic [GW-1:0]   gain_d, gain_q;
  logic [HC_W-1:0] hold_cnt_d, hold_cnt_q;
  logic            flag_d, flag_q;

  logic [SW-1:0]   atk_sum;
  logic            atk_full;
  logic [GW-1:0]   atk_gain;
  logic [GW-1:0]   rel_gain;

  always_comb begin
    atk_sum  = {1'b0, gain_q} + ATK;
    atk_full = (atk_sum >= {1'b0, GMAX});
    atk_gain = atk_full ? GMAX : atk_sum[GW-1:0];
    rel_gain = (gain_q <= REL) ? '0 : (gain_q - REL);
  end

  // A flag arriving with a sample is used by that same sample.
  always_comb begin
    flag_d     = gate_valid ? (gate_in != '0) : flag_q;
    state_d    = state_q;
    gain_d     = gain_q;
    hold_cnt_d = hold_cnt_q;

    if (audio_valid) begin
      unique case (state_q)
        CLOSED: begin
          gain_d = '0;
          if (flag_d) begin
            gain_d  = atk_gain;
            state_d = atk_full ? OPEN : ATTACK;
          end
        end
        ATTACK: begin
          if (!flag_d) begin
            state_d = RELEASE;
          end else begin
            gain_d  = atk_gain;
            state_d = atk_full ? OPEN : ATTACK;
          end
        end
        OPEN: begin
          gain_d = GMAX;
          if (!flag_d) begin
            if (HOLD_SAMPLES == 0) begin
              state_d = RELEASE;
            end else begin
              state_d    = HOLD;
              hold_cnt_d = HOLD_INIT;
            end
          end
        end
        HOLD: begin
          if (flag_d) begin
            state_d = OPEN;
          end else if (hold_cnt_q == '0) begin
            state_d = RELEASE;
          end else begin
            hold_cnt_d = hold_cnt_q - 1'b1;
          end
        end
        RELEASE: begin
          if (flag_d) begin
            gain_d  = atk_gain;
            state_d = atk_full ? OPEN : ATTACK;
          end else begin
            gain_d = rel_gain;
            if (rel_gain == '0) begin
              state_d = CLOSED;
            end
          end
        end
        default: begin
          state_d = CLOSED;
          gain_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLOSED;
      gain_q     <= '0;
      hold_cnt_q <= '0;
      flag_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gain_q     <= gain_d;
      hold_cnt_q <= hold_cnt_d;
      flag_q     <= flag_d;
    end
  end

  // The multiplier sees the pre-update gain, so a new gain applies from the next sample.
  gain_mult #(
    .WIDTH  (WIDTH),
    .GAIN_W (GAIN_W)
  ) u_gain_mult (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (audio_valid),
    .sample    (audio_in),
    .gain      (gain_q),
    .out       (audio_out),
    .out_valid (audio_out_valid)
  );

  assign gate_open = (state_q == ATTACK) || (state_q == OPEN) || (state_q == HOLD);
  assign gain_out  = gain_q;

endmodule

`default_nettype wire

// File: tb/tb_gate_envelope.sv
// +----------------------------------------------------------------------------+
// | tb_gate_envelope: directed vectors with a queue scoreboard for gate_envelope.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_gate_envelope;
  import gate_pkg::*;

  logic               clk;
  logic               rst_n;
  logic [15:0]        gate_in;
  logic               gate_valid;
  logic signed [15:0] audio_in;
  logic               audio_valid;
  logic signed [15:0] audio_out;
  logic               audio_out_valid;
  logic               gate_open;
  logic [8:0]         gain_out;

  int checks = 0;
  int passes = 0;
  logic signed [15:0] sb[$];
  logic av_prev;

  gate_envelope #(
    .WIDTH        (16),
    .GAIN_W       (8),
    .ATTACK_STEP  (64),
    .RELEASE_STEP (32),
    .HOLD_SAMPLES (3)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .gate_in         (gate_in),
    .gate_valid      (gate_valid),
    .audio_in        (audio_in),
    .audio_valid     (audio_valid),
    .audio_out       (audio_out),
    .audio_out_valid (audio_out_valid),
    .gate_open       (gate_open),
    .gain_out        (gain_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Scoreboard monitor: pops one expected sample per output pulse.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) av_prev <= 1'b0;
    else        av_prev <= audio_valid;
  end

  always @(negedge clk) begin
    if (rst_n && (audio_out_valid || av_prev)) begin
      chk("valid_latency", int'(audio_out_valid), int'(av_prev));
    end
    if (audio_out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", int'(audio_out), 99999);
      end else begin
        chk("audio_out", int'(audio_out), int'(sb.pop_front()));
      end
    end
  end

  task automatic samp(input logic signed [15:0] d, input logic signed [15:0] e,
                      input bit with_gate, input logic [15:0] gv);
    @(posedge clk); #1;
    audio_in    = d;
    audio_valid = 1'b1;
    gate_valid  = with_gate;
    gate_in     = gv;
    sb.push_back(e);
    @(posedge clk); #1;
    audio_valid = 1'b0;
    gate_valid  = 1'b0;
  endtask

  task automatic gate(input logic [15:0] v);
    @(posedge clk); #1;
    gate_valid = 1'b1;
    gate_in    = v;
    @(posedge clk); #1;
    gate_valid = 1'b0;
  endtask

  initial begin
    logic signed [15:0] t3_exp [14];
    logic signed [15:0] rel_exp [8];
    t3_exp  = '{1000, 1000, 1000, 1000, 1000, 875, 750, 625, 500, 375, 250, 125, 0, 0};
    rel_exp = '{1000, 1000, 1000, 1000, 1000, 875, 750, 625};

    rst_n = 1'b0; gate_in = '0; gate_valid = 1'b0; audio_in = '0; audio_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_audio_out", int'(audio_out), 0);
    chk("rst_valid", int'(audio_out_valid), 0);
    chk("rst_gate_open", int'(gate_open), 0);
    chk("rst_gain", int'(gain_out), 0);
    rst_n = 1'b1;

    // Flag never set: output stays silent.
    for (int i = 0; i < 3; i++) samp(16'sd1000, 16'sd0, 1'b0, 16'd0);
    chk("t1_gate_open", int'(gate_open), 0);

    // Attack from closed up to unity gain.
    gate(16'd1);
    samp(16'sd1000, 16'sd0, 1'b0, 16'd0);
    chk("t2_gate_open_first", int'(gate_open), 1);
    chk("t2_gain_first", int'(gain_out), 64);
    samp(16'sd1000, 16'sd250, 1'b0, 16'd0);
    samp(16'sd1000, 16'sd500, 1'b0, 16'd0);
    samp(16'sd1000, 16'sd750, 1'b0, 16'd0);
    samp(16'sd1000, 16'sd1000, 1'b0, 16'd0);
    chk("t2_gain_end", int'(gain_out), 256);
    chk("t2_state_open", int'(dut.state_q), int'(OPEN));

    // Hold then release down to closed.
    gate(16'd0);
    for (int i = 0; i < 14; i++) begin
      samp(16'sd1000, t3_exp[i], 1'b0, 16'd0);
      if (i == 2) chk("t3_open_in_hold", int'(gate_open), 1);
      if (i == 3) begin
        chk("t3_closed_in_release", int'(gate_open), 0);
        chk("t3_gain_at_release", int'(gain_out), 256);
      end
    end
    chk("t3_gain_end", int'(gain_out), 0);
    chk("t3_state_closed", int'(dut.state_q), int'(CLOSED));

    // Attack again, then most-negative sample at unity gain.
    gate(16'd1);
    samp(16'sd1000, 16'sd0, 1'b0, 16'd0);
    samp(16'sd1000, 16'sd250, 1'b0, 16'd0);
    samp(16'sd1000, 16'sd500, 1'b0, 16'd0);
    samp(16'sd1000, 16'sd750, 1'b0, 16'd0);
    samp(-16'sd32768, -16'sd32768, 1'b0, 16'd0);

    // Release to gain 128, then re-open with a flag on the same cycle as a sample.
    gate(16'd0);
    for (int i = 0; i < 8; i++) samp(16'sd1000, rel_exp[i], 1'b0, 16'd0);
    chk("t5_gain_128", int'(gain_out), 128);
    samp(16'sd1000, 16'sd500, 1'b1, 16'd1);
    chk("t5_gain_192", int'(gain_out), 192);
    chk("t5_gate_open", int'(gate_open), 1);
    samp(16'sd1000, 16'sd750, 1'b0, 16'd0);
    chk("t5_gain_256", int'(gain_out), 256);
    chk("t5_state_open", int'(dut.state_q), int'(OPEN));

    // Release to 128 again for -1 (floor rounding), then drain to closed.
    gate(16'd0);
    for (int i = 0; i < 8; i++) samp(16'sd0, 16'sd0, 1'b0, 16'd0);
    samp(-16'sd1, -16'sd1, 1'b0, 16'd0);
    for (int i = 0; i < 3; i++) samp(16'sd0, 16'sd0, 1'b0, 16'd0);
    chk("t4_closed_again", int'(gain_out), 0);

    // Asynchronous reset mid-attack at gain 128.
    gate(16'd1);
    samp(16'sd1000, 16'sd0, 1'b0, 16'd0);
    samp(16'sd1000, 16'sd250, 1'b0, 16'd0);
    chk("t6_gain_before", int'(gain_out), 128);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_audio_out", int'(audio_out), 0);
    chk("t6_rst_valid", int'(audio_out_valid), 0);
    chk("t6_rst_gain", int'(gain_out), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    samp(16'sd1000, 16'sd0, 1'b0, 16'd0);

    // 32767 at gain 128.
    gate(16'd1);
    samp(16'sd0, 16'sd0, 1'b0, 16'd0);
    samp(16'sd0, 16'sd0, 1'b0, 16'd0);
    samp(16'sd32767, 16'sd16383, 1'b0, 16'd0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
